// File: rtl/vscale_hazard_pkg.sv
// rtl/vscale_hazard_pkg.sv - shared record type, select constant and width helpers for the vscale hazard unit
package vscale_hazard_pkg;

  // Record fields are sized for the largest supported configuration
  // (REG_ADDR_WIDTH <= 8, N_STAGES <= 4); narrower values are zero-extended.
  localparam int REC_RD_W  = 8;
  localparam int REC_LAT_W = 3;

  // Bypass select value meaning "take the register file"
  localparam int BYP_RF = 0;

  typedef struct packed {
    logic                 valid;
    logic [REC_RD_W-1:0]  rd;
    logic [REC_LAT_W-1:0] lat;
  } hazard_rec_t;

  function automatic int sel_w(input int n_stages);
    return $clog2(n_stages + 1);
  endfunction

  function automatic int lat_w(input int n_stages);
    return $clog2(n_stages + 1);
  endfunction

endpackage

// File: rtl/vscale_hazard_if.sv
// rtl/vscale_hazard_if.sv - DX-stage hazard request/response bundle for vscale_hazard_unit
interface vscale_hazard_if #(
  parameter int N_STAGES       = 2,
  parameter int REG_ADDR_WIDTH = 5
);
  import vscale_hazard_pkg::*;

  localparam int SEL_W = sel_w(N_STAGES);
  localparam int LAT_W = lat_w(N_STAGES);

  logic                      dx_valid;
  logic [REG_ADDR_WIDTH-1:0] rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] rs2_addr;
  logic                      rs1_used;
  logic                      rs2_used;
  logic [REG_ADDR_WIDTH-1:0] rd_addr;
  logic                      rd_wr;
  logic [LAT_W-1:0]          rd_lat;
  logic                      rd_long;
  logic                      long_done;
  logic [REG_ADDR_WIDTH-1:0] long_done_rd;
  logic                      stall_ext;
  logic                      flush;
  logic                      stall_DX_hazard;
  logic [SEL_W-1:0]          bypass_rs1_sel;
  logic [SEL_W-1:0]          bypass_rs2_sel;

  modport master (
    output dx_valid, rs1_addr, rs2_addr, rs1_used, rs2_used,
    output rd_addr, rd_wr, rd_lat, rd_long,
    output long_done, long_done_rd, stall_ext, flush,
    input  stall_DX_hazard, bypass_rs1_sel, bypass_rs2_sel
  );

  modport slave (
    input  dx_valid, rs1_addr, rs2_addr, rs1_used, rs2_used,
    input  rd_addr, rd_wr, rd_lat, rd_long,
    input  long_done, long_done_rd, stall_ext, flush,
    output stall_DX_hazard, bypass_rs1_sel, bypass_rs2_sel
  );

endinterface

// File: rtl/vscale_hazard_match.sv
// rtl/vscale_hazard_match.sv - youngest-match priority encoder for one DX source operand
module vscale_hazard_match
  import vscale_hazard_pkg::*;
#(
  parameter  int N_STAGES       = 2,
  parameter  int REG_ADDR_WIDTH = 5,
  localparam int SEL_W          = sel_w(N_STAGES)
) (
  input  logic [REG_ADDR_WIDTH-1:0] src_addr,
  input  logic                      src_used,
  input  hazard_rec_t [N_STAGES:1]  recs,
  output logic [SEL_W-1:0]          sel,
  output logic                      hazard
);

  // Walk oldest to youngest so the youngest matching stage has the final say;
  // a not-yet-ready young match hides any ready older copy of the register.
  always_comb begin
    sel    = SEL_W'(BYP_RF);
    hazard = 1'b0;
    for (int k = N_STAGES; k >= 1; k--) begin
      if (src_used && (src_addr != '0) && recs[k].valid &&
          (recs[k].rd == REC_RD_W'(src_addr))) begin
        if (recs[k].lat <= REC_LAT_W'(k)) begin
          sel    = SEL_W'(k);
          hazard = 1'b0;
        end else begin
          sel    = SEL_W'(BYP_RF);
          hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vscale_hazard_unit.sv
// rtl/vscale_hazard_unit.sv - DX data-hazard stall and bypass control; long-op scoreboard under VSCALE_LONG_OP_EN
module vscale_hazard_unit
  import vscale_hazard_pkg::*;
#(
  parameter int N_STAGES       = 2,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic           clk,
  input logic           reset_n,
  vscale_hazard_if.slave hz
);

  localparam int SEL_W = sel_w(N_STAGES);

  hazard_rec_t [N_STAGES:1] recs;
  hazard_rec_t              new_rec;
  logic [SEL_W-1:0]         sel_rs1;
  logic [SEL_W-1:0]         sel_rs2;
  logic                     haz_rs1;
  logic                     haz_rs2;
  logic                     long_haz;
  logic                     pipe_wr;
  logic                     stall;
  logic                     issue;

  vscale_hazard_match #(
    .N_STAGES       (N_STAGES),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_match_rs1 (
    .src_addr (hz.rs1_addr),
    .src_used (hz.rs1_used),
    .recs     (recs),
    .sel      (sel_rs1),
    .hazard   (haz_rs1)
  );

  vscale_hazard_match #(
    .N_STAGES       (N_STAGES),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_match_rs2 (
    .src_addr (hz.rs2_addr),
    .src_used (hz.rs2_used),
    .recs     (recs),
    .sel      (sel_rs2),
    .hazard   (haz_rs2)
  );

`ifdef VSCALE_LONG_OP_EN
  localparam int SB_W = 2 ** REG_ADDR_WIDTH;

  logic [SB_W-1:0] sb;
  logic            long_issue;

  // Pending multi-cycle results block readers (RAW) and new writers (WAW)
  always_comb begin
    long_haz = 1'b0;
    if (hz.rs1_used && (hz.rs1_addr != '0) && sb[hz.rs1_addr]) long_haz = 1'b1;
    if (hz.rs2_used && (hz.rs2_addr != '0) && sb[hz.rs2_addr]) long_haz = 1'b1;
    if (hz.rd_wr && (hz.rd_addr != '0) && sb[hz.rd_addr])      long_haz = 1'b1;
  end

  assign long_issue = hz.dx_valid && hz.rd_wr && hz.rd_long && (hz.rd_addr != '0) &&
                      !stall && !hz.stall_ext && !hz.flush;
  assign pipe_wr    = hz.rd_wr && !hz.rd_long;

  // Completion clears, issue sets; the set is written last so it wins a same-register collision
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb <= '0;
    end else begin
      if (hz.long_done) sb[hz.long_done_rd] <= 1'b0;
      if (long_issue)   sb[hz.rd_addr]      <= 1'b1;
    end
  end
`else
  logic unused_long;

  assign unused_long = ^{hz.rd_long, hz.long_done, hz.long_done_rd};
  assign long_haz    = 1'b0;
  assign pipe_wr     = hz.rd_wr;
`endif

  assign stall = hz.dx_valid && !hz.flush && (haz_rs1 || haz_rs2 || long_haz);
  assign issue = hz.dx_valid && pipe_wr && (hz.rd_addr != '0) &&
                 !stall && !hz.stall_ext && !hz.flush;

  assign hz.stall_DX_hazard = stall;
  assign hz.bypass_rs1_sel  = sel_rs1;
  assign hz.bypass_rs2_sel  = sel_rs2;

  // Record entering stage 1: the DX write when it issues, otherwise a bubble
  always_comb begin
    new_rec       = '0;
    new_rec.valid = issue;
    new_rec.rd    = REC_RD_W'(hz.rd_addr);
    new_rec.lat   = REC_LAT_W'(hz.rd_lat);
  end

  // Write-record shift register; flush kills every stage even while frozen by stall_ext
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      recs <= '0;
    end else if (hz.flush) begin
      for (int k = 1; k <= N_STAGES; k++) recs[k].valid <= 1'b0;
    end else if (!hz.stall_ext) begin
      recs[1] <= new_rec;
      for (int k = 2; k <= N_STAGES; k++) recs[k] <= recs[k-1];
    end
  end

endmodule

// File: tb/tb_vscale_hazard_unit.sv
// tb/tb_vscale_hazard_unit.sv - directed self-checking bench for vscale_hazard_unit (N_STAGES=2)
module tb_vscale_hazard_unit;

  logic clk;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  vscale_hazard_if #(.N_STAGES(2), .REG_ADDR_WIDTH(5)) hz ();

  vscale_hazard_unit #(.N_STAGES(2), .REG_ADDR_WIDTH(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hz      (hz)
  );

  initial clk = 1'b0;

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                       input logic wr, input logic [1:0] lat, input logic lng);
    hz.dx_valid     = v;
    hz.rs1_addr     = r1;
    hz.rs1_used     = u1;
    hz.rs2_addr     = r2;
    hz.rs2_used     = u2;
    hz.rd_addr      = rd;
    hz.rd_wr        = wr;
    hz.rd_lat       = lat;
    hz.rd_long      = lng;
    hz.long_done    = 1'b0;
    hz.long_done_rd = 5'd0;
    hz.stall_ext    = 1'b0;
    hz.flush        = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic drain();
    repeat (3) begin
      @(negedge clk);
      idle();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    @(negedge clk); #1;
    checks++; if (hz.stall_DX_hazard !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", hz.stall_DX_hazard); end
    checks++; if (hz.bypass_rs1_sel !== 2'd0) begin errors++; $display("FAIL reset_sel1: got %0d expected 0", hz.bypass_rs1_sel); end
    checks++; if (hz.bypass_rs2_sel !== 2'd0) begin errors++; $display("FAIL reset_sel2: got %0d expected 0", hz.bypass_rs2_sel); end
    reset_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 2'd0, 1'b0); #1;
    checks++; if (hz.bypass_rs1_sel !== 2'd0) begin errors++; $display("FAIL empty_sel1: got %0d expected 0", hz.bypass_rs1_sel); end
    checks++; if (hz.stall_DX_hazard !== 1'b0) begin errors++; $display("FAIL empty_stall: got %0b expected 0", hz.stall_DX_hazard); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 2'd1, 1'b0); #1;
    checks++; if (hz.stall_DX_hazard !== 1'b0) begin errors++; $display("FAIL b2b_issue_stall: got %0b expected 0", hz.stall_DX_hazard); end
    @(negedge clk);
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 2'd1, 1'b0); #1;
    checks++; if (hz.bypass_rs1_sel !== 2'd1) begin errors++; $display("FAIL b2b_sel1_stage1: got %0d expected 1", hz.bypass_rs1_sel); end
    checks++; if (hz.stall_DX_hazard !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %0b expected 0", hz.stall_DX_hazard); end
    @(negedge clk);
    drive(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 2'd0, 1'b0); #1;
    checks++; if (hz.bypass_rs1_sel !== 2'd2) begin errors++; $display("FAIL b2b_sel1_stage2: got %0d expected 2", hz.bypass_rs1_sel); end
    checks++; if (hz.bypass_rs2_sel !== 2'd1) begin errors++; $display("FAIL b2b_sel2_stage1: got %0d expected 1", hz.bypass_rs2_sel); end
    checks++; if (hz.stall_DX_hazard !== 1'b0) begin errors++; $display("FAIL b2b_chain_stall: got %0b expected 0", hz.stall_DX_hazard); end
    drain();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'd2, 1'b0);
    @(negedge clk);
    drive(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 2'd0, 1'b0); #1;
    checks++; if (hz.stall_DX_hazard !== 1'b1) begin errors++; $display("FAIL load_use_stall: got %0b expected 1", hz.stall_DX_hazard); end
    checks++; if (hz.bypass_rs2_sel !== 2'd0) begin errors++; $display("FAIL load_use_sel_wait: got %0d expected 0", hz.bypass_rs2_sel); end
    @(negedge clk); #1;
    checks++; if (hz.stall_DX_hazard !== 1'b0) begin errors++; $display("FAIL load_use_release: got %0b expected 0", hz.stall_DX_hazard); end
    checks++; if (hz.bypass_rs2_sel !== 2'd2) begin errors++; $display("FAIL load_use_sel2: got %0d expected 2", hz.bypass_rs2_sel); end
    drain();
  endtask

  task automatic test_shadowing();
    @(negedge clk);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 2'd1, 1'b0);
    @(negedge clk);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 2'd2, 1'b0);
    @(negedge clk);
    drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 2'd0, 1'b0); #1;
    checks++; if (hz.stall_DX_hazard !== 1'b1) begin errors++; $display("FAIL shadow_stall: got %0b expected 1", hz.stall_DX_hazard); end
    checks++; if (hz.bypass_rs1_sel !== 2'd0) begin errors++; $display("FAIL shadow_sel1: got %0d expected 0", hz.bypass_rs1_sel); end
    checks++; if (hz.bypass_rs2_sel !== 2'd0) begin errors++; $display("FAIL x0_sel2: got %0d expected 0", hz.bypass_rs2_sel); end
    @(negedge clk); #1;
    checks++; if (hz.stall_DX_hazard !== 1'b0) begin errors++; $display("FAIL shadow_release: got %0b expected 0", hz.stall_DX_hazard); end
    checks++; if (hz.bypass_rs1_sel !== 2'd2) begin errors++; $display("FAIL shadow_sel1_late: got %0d expected 2", hz.bypass_rs1_sel); end
    drain();
  endtask

  task automatic test_stall_flush();
    @(negedge clk);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 2'd1, 1'b0);
    @(negedge clk);
    drive(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
    hz.stall_ext = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      checks++; if (hz.bypass_rs1_sel !== 2'd1) begin errors++; $display("FAIL stall_ext_sel1 cycle %0d: got %0d expected 1", c, hz.bypass_rs1_sel); end
      checks++; if (hz.stall_DX_hazard !== 1'b0) begin errors++; $display("FAIL stall_ext_hazard cycle %0d: got %0b expected 0", c, hz.stall_DX_hazard); end
    end
    @(negedge clk);
    hz.flush = 1'b1; #1;
    checks++; if (hz.stall_DX_hazard !== 1'b0) begin errors++; $display("FAIL flush_gates_stall: got %0b expected 0", hz.stall_DX_hazard); end
    checks++; if (hz.bypass_rs1_sel !== 2'd1) begin errors++; $display("FAIL flush_pre_sel1: got %0d expected 1", hz.bypass_rs1_sel); end
    @(negedge clk);
    hz.flush = 1'b0;
    hz.stall_ext = 1'b0; #1;
    checks++; if (hz.bypass_rs1_sel !== 2'd0) begin errors++; $display("FAIL flush_cleared_sel1: got %0d expected 0", hz.bypass_rs1_sel); end
    checks++; if (hz.stall_DX_hazard !== 1'b0) begin errors++; $display("FAIL flush_cleared_stall: got %0b expected 0", hz.stall_DX_hazard); end
    drain();
  endtask

  task automatic test_long_op();
`ifdef VSCALE_LONG_OP_EN
    @(negedge clk);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 2'd1, 1'b1); #1;
    checks++; if (hz.stall_DX_hazard !== 1'b0) begin errors++; $display("FAIL long_issue_stall: got %0b expected 0", hz.stall_DX_hazard); end
    @(negedge clk);
    drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0); #1;
    checks++; if (hz.stall_DX_hazard !== 1'b1) begin errors++; $display("FAIL long_raw_stall0: got %0b expected 1", hz.stall_DX_hazard); end
    @(negedge clk); #1;
    checks++; if (hz.stall_DX_hazard !== 1'b1) begin errors++; $display("FAIL long_raw_stall1: got %0b expected 1", hz.stall_DX_hazard); end
    @(negedge clk);
    hz.long_done = 1'b1;
    hz.long_done_rd = 5'd9; #1;
    checks++; if (hz.stall_DX_hazard !== 1'b1) begin errors++; $display("FAIL long_done_cycle_stall: got %0b expected 1", hz.stall_DX_hazard); end
    @(negedge clk);
    hz.long_done = 1'b0; #1;
    checks++; if (hz.stall_DX_hazard !== 1'b0) begin errors++; $display("FAIL long_raw_release: got %0b expected 0", hz.stall_DX_hazard); end
    checks++; if (hz.bypass_rs1_sel !== 2'd0) begin errors++; $display("FAIL long_raw_sel1: got %0d expected 0", hz.bypass_rs1_sel); end
    @(negedge clk);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 2'd1, 1'b1);
    @(negedge clk);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 2'd1, 1'b0); #1;
    checks++; if (hz.stall_DX_hazard !== 1'b1) begin errors++; $display("FAIL waw_stall: got %0b expected 1", hz.stall_DX_hazard); end
    @(negedge clk);
    hz.long_done = 1'b1;
    hz.long_done_rd = 5'd9; #1;
    checks++; if (hz.stall_DX_hazard !== 1'b1) begin errors++; $display("FAIL waw_done_cycle: got %0b expected 1", hz.stall_DX_hazard); end
    @(negedge clk);
    hz.long_done = 1'b0; #1;
    checks++; if (hz.stall_DX_hazard !== 1'b0) begin errors++; $display("FAIL waw_release: got %0b expected 0", hz.stall_DX_hazard); end
`else
    @(negedge clk);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 2'd2, 1'b1);
    hz.long_done = 1'b1;
    hz.long_done_rd = 5'd10;
    @(negedge clk);
    drive(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0); #1;
    checks++; if (hz.stall_DX_hazard !== 1'b1) begin errors++; $display("FAIL long_as_pipe_stall: got %0b expected 1", hz.stall_DX_hazard); end
    @(negedge clk); #1;
    checks++; if (hz.stall_DX_hazard !== 1'b0) begin errors++; $display("FAIL long_as_pipe_release: got %0b expected 0", hz.stall_DX_hazard); end
    checks++; if (hz.bypass_rs1_sel !== 2'd2) begin errors++; $display("FAIL long_as_pipe_sel1: got %0d expected 2", hz.bypass_rs1_sel); end
`endif
    drain();
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 2'd1, 1'b1);
    @(negedge clk);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'd2, 1'b0);
    @(negedge clk);
    drive(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 2'd0, 1'b0); #1;
    checks++; if (hz.stall_DX_hazard !== 1'b1) begin errors++; $display("FAIL pre_reset_stall: got %0b expected 1", hz.stall_DX_hazard); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (hz.stall_DX_hazard !== 1'b0) begin errors++; $display("FAIL async_reset_stall: got %0b expected 0", hz.stall_DX_hazard); end
    checks++; if (hz.bypass_rs2_sel !== 2'd0) begin errors++; $display("FAIL async_reset_sel2: got %0d expected 0", hz.bypass_rs2_sel); end
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0); #1;
    checks++; if (hz.stall_DX_hazard !== 1'b0) begin errors++; $display("FAIL post_reset_sb_stall: got %0b expected 0", hz.stall_DX_hazard); end
    checks++; if (hz.bypass_rs1_sel !== 2'd0) begin errors++; $display("FAIL post_reset_sel1: got %0d expected 0", hz.bypass_rs1_sel); end
    drain();
  endtask

  // Scenario sequence and summary
  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_shadowing();
    test_stall_flush();
    test_long_op();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
